// File: rtl/e203_dtcm_ram_ctrl_if.sv
// Command/response channel between one requester and the DTCM controller.
// The requester drives commands and response-ready; the controller answers.
interface e203_dtcm_ram_ctrl_if #(
    parameter int AW = 14,
    parameter int DW = 32,
    parameter int MW = 4
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_read;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [MW-1:0] cmd_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output cmd_valid,
        output cmd_read,
        output cmd_addr,
        output cmd_wdata,
        output cmd_wmask,
        output rsp_ready,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    modport slave (
        input  cmd_valid,
        input  cmd_read,
        input  cmd_addr,
        input  cmd_wdata,
        input  cmd_wmask,
        input  rsp_ready,
        output cmd_ready,
        output rsp_valid,
        output rsp_rdata
    );
endinterface

// File: rtl/e203_dtcm_ram_ctrl.sv
// DTCM RAM controller: round-robin sharing of one single-port macro
// between the LSU (port a) and ICB/DMA (port b), plus macro power control.

// One-entry response slot per port.
module e203_dtcm_rsp_slot #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          grant,
    input  logic          read,
    input  logic          rsp_ready,
    input  logic [DW-1:0] ram_dout,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata
);
    logic          rd_pend;
    logic [DW-1:0] hold;

    // Macro data is only valid on the first response cycle, so pass it
    // straight through then and serve the captured copy afterwards.
    assign rsp_rdata = rd_pend ? ram_dout : hold;

    // Slot fills on grant, captures read data once, drains on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rd_pend   <= 1'b0;
            hold      <= '0;
        end else if (grant) begin
            rsp_valid <= 1'b1;
            rd_pend   <= read;
            hold      <= '0;
        end else begin
            rd_pend <= 1'b0;
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
                hold      <= '0;
            end else if (rd_pend) begin
                hold <= ram_dout;
            end
        end
    end
endmodule

module e203_dtcm_ram_ctrl #(
    parameter int AW       = 14,
    parameter int DW       = 32,
    parameter int MW       = 4,
    parameter int IDLE_CYC = 16,
    parameter int WAKE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    e203_dtcm_ram_ctrl_if.slave  a,
    e203_dtcm_ram_ctrl_if.slave  b,
    input  logic                 pwr_deep_req,
    output logic                 ram_cs,
    output logic                 ram_we,
    output logic [AW-1:0]        ram_addr,
    output logic [MW-1:0]        ram_wem,
    output logic [DW-1:0]        ram_din,
    input  logic [DW-1:0]        ram_dout,
    output logic                 ram_ls,
    output logic                 ram_ds,
    output logic                 ram_sd
);
    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_LS,
        ST_DS,
        ST_WAKE
    } pwr_state_e;

    localparam logic [7:0] IDLE_MAX  = 8'(IDLE_CYC);
    localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYC - 1);

    pwr_state_e    state;
    logic [7:0]    idle_cnt;
    logic [3:0]    wake_cnt;
    logic          rr_b;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;

    logic active;
    logic any_valid;
    logic idle_now;
    logic slots_empty;
    logic a_elig;
    logic b_elig;
    logic gnt_a;
    logic gnt_b;

    // Shutdown is never used by this controller.
    assign ram_sd = 1'b0;

    // Commands are only accepted when the macro is fully awake; holding
    // off during reset keeps every output quiet while rst_n is low.
    assign active    = rst_n && (state == ST_ACTIVE);
    assign any_valid = a.cmd_valid || b.cmd_valid;

    // A port may issue when its slot is free or is being freed right now.
    assign a_elig = a.cmd_valid && (!a.rsp_valid || a.rsp_ready);
    assign b_elig = b.cmd_valid && (!b.rsp_valid || b.rsp_ready);

    // rr_b set means port b is favoured on the next collision.
    assign gnt_a = active && a_elig && (!b_elig || !rr_b);
    assign gnt_b = active && b_elig && (!a_elig || rr_b);

    assign a.cmd_ready = gnt_a;
    assign b.cmd_ready = gnt_b;

    assign idle_now    = !any_valid && !ram_cs;
    assign slots_empty = !a.rsp_valid && !b.rsp_valid;

    // Macro command mux; address and data park on their last values.
    always_comb begin
        ram_cs   = gnt_a || gnt_b;
        ram_we   = 1'b0;
        ram_wem  = '0;
        ram_addr = addr_q;
        ram_din  = din_q;
        if (gnt_a) begin
            ram_we   = !a.cmd_read;
            ram_addr = a.cmd_addr;
            ram_wem  = a.cmd_read ? '0 : a.cmd_wmask;
            ram_din  = a.cmd_wdata;
        end else if (gnt_b) begin
            ram_we   = !b.cmd_read;
            ram_addr = b.cmd_addr;
            ram_wem  = b.cmd_read ? '0 : b.cmd_wmask;
            ram_din  = b.cmd_wdata;
        end
    end

    // Round-robin pointer and parked macro address/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_b   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else if (ram_cs) begin
            rr_b   <= gnt_a;
            addr_q <= ram_addr;
            din_q  <= ram_din;
        end
    end

    // Power FSM: idle light sleep, requested deep sleep, timed wake-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_ACTIVE;
            idle_cnt <= '0;
            wake_cnt <= '0;
            ram_ls   <= 1'b0;
            ram_ds   <= 1'b0;
        end else begin
            case (state)
                ST_ACTIVE: begin
                    if (!idle_now) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt >= IDLE_MAX - 8'd1
                                 && slots_empty) begin
                        state    <= ST_LS;
                        ram_ls   <= 1'b1;
                        idle_cnt <= '0;
                    end else if (idle_cnt != IDLE_MAX) begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
                end
                ST_LS: begin
                    if (any_valid) begin
                        state    <= ST_WAKE;
                        ram_ls   <= 1'b0;
                        wake_cnt <= '0;
                    end else if (pwr_deep_req) begin
                        state  <= ST_DS;
                        ram_ds <= 1'b1;
                    end
                end
                ST_DS: begin
                    if (any_valid || !pwr_deep_req) begin
                        state    <= ST_WAKE;
                        ram_ls   <= 1'b0;
                        ram_ds   <= 1'b0;
                        wake_cnt <= '0;
                    end
                end
                ST_WAKE: begin
                    if (wake_cnt == WAKE_LAST) begin
                        state    <= ST_ACTIVE;
                        idle_cnt <= '0;
                    end else begin
                        wake_cnt <= wake_cnt + 4'd1;
                    end
                end
                default: begin
                    state  <= ST_ACTIVE;
                    ram_ls <= 1'b0;
                    ram_ds <= 1'b0;
                end
            endcase
        end
    end

    e203_dtcm_rsp_slot #(.DW(DW)) u_slot_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .grant     (gnt_a),
        .read      (a.cmd_read),
        .rsp_ready (a.rsp_ready),
        .ram_dout  (ram_dout),
        .rsp_valid (a.rsp_valid),
        .rsp_rdata (a.rsp_rdata)
    );

    e203_dtcm_rsp_slot #(.DW(DW)) u_slot_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .grant     (gnt_b),
        .read      (b.cmd_read),
        .rsp_ready (b.rsp_ready),
        .ram_dout  (ram_dout),
        .rsp_valid (b.rsp_valid),
        .rsp_rdata (b.rsp_rdata)
    );
endmodule

// File: doc/e203_dtcm_ram_ctrl.md
Name: e203_dtcm_ram_ctrl

Overview:
- Sequences and shares the single-port DTCM RAM macro between two requesters.
  - Port A: core LSU.
  - Port B: external ICB/DMA.
- Round-robin arbitration with a valid/ready command handshake and a registered response channel per port.
- Owns the RAM low-power pins (ls/ds/sd): idle-driven light sleep, requested deep sleep, and a timed wake-up sequence.

Parameters:
- AW, 14, RAM word address width.
- DW, 32, data width.
- MW, 4, write-enable mask width (DW/8).
- IDLE_CYC, 16, consecutive idle cycles in ACTIVE before entering light sleep (1..255).
- WAKE_CYC, 2, cycles ls/ds held deasserted before the first access after wake (1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- a_cmd_valid  in  1  port A request
- a_cmd_ready  out  1  port A accepted
- a_cmd_read  in  1  1=read, 0=write
- a_cmd_addr  in  AW  word address
- a_cmd_wdata  in  DW  write data
- a_cmd_wmask  in  MW  byte mask
- a_rsp_valid  out  1  response available
- a_rsp_ready  in  1  response taken
- a_rsp_rdata  out  DW  read data (0 for writes)
- b_cmd_* / b_rsp_*  (same set as port A)  port B
- pwr_deep_req  in  1  request deep sleep (level)
- ram_cs  out  1  chip select
- ram_we  out  1  write enable
- ram_addr  out  AW  address
- ram_wem  out  MW  write mask
- ram_din  out  DW  write data
- ram_dout  in  DW  read data, valid the cycle after a cs&!we access
- ram_ls  out  1  light sleep
- ram_ds  out  1  deep sleep
- ram_sd  out  1  shutdown (always 0; driven for macro completeness)

Behaviour:
Reset values:
- All outputs 0, except ram_ls=0 and ram_ds=0 (state ACTIVE).
- RR pointer favours A; idle counter 0; both rsp slots empty.

Power FSM (states ACTIVE, LS, DS, WAKE):
- ACTIVE
  - Idle counter increments on cycles with ram_cs=0 and no cmd_valid; clears otherwise.
  - Counter reaching IDLE_CYC with both rsp slots empty -> LS.
- LS
  - ram_ls=1.
  - Any cmd_valid -> WAKE.
  - Otherwise, pwr_deep_req=1 -> DS.
  - cmd_valid has priority over pwr_deep_req.
- DS
  - ram_ls=1, ram_ds=1.
  - Any cmd_valid, or pwr_deep_req=0 -> WAKE.
- WAKE
  - ram_ls=0, ram_ds=0.
  - Wake counter runs WAKE_CYC cycles, then -> ACTIVE with idle counter cleared.
- cmd_ready is 0 in every state except ACTIVE.
- All state registers sit on the rst_n async domain. Reset mid-wake or mid-access returns to ACTIVE with slots empty; in-flight data is discarded.

Arbitration (ACTIVE only):
- A port is eligible when cmd_valid=1 and its rsp slot is empty, or its slot is being emptied this cycle (rsp_valid & rsp_ready).
- One eligible port: grant it.
- Both eligible: grant the port not granted last; the pointer updates on every grant.
- cmd_ready = grant; the handshake completes in the same cycle.
- ram_cs=1 that cycle. Combinational from the granted port:
  - ram_we = !cmd_read
  - ram_addr = cmd_addr
  - ram_wem = cmd_read ? 0 : cmd_wmask
  - ram_din = cmd_wdata
- With no grant: ram_cs=0, ram_we=0, and ram_wem=0. ram_addr and ram_din hold their last values.

Response:
- Cycle after grant: the slot sets rsp_valid=1.
  - Read: rsp_rdata captured from ram_dout.
  - Write: rsp_rdata = 0.
- Latency is 1 cycle, command handshake to rsp_valid.
- rsp_valid and rsp_rdata hold stable until rsp_ready; cleared the cycle after the handshake.
- At most one outstanding transaction per port.
- Back-to-back throughput is 1 per cycle per port when rsp_ready is held high.

Invariant:
- ram_cs=1 never coincides with ram_ls=1 or ram_ds=1.

Test Plan:
- Reset with rsp_ready=1:
  - Reset low: all outputs 0.
  - After release: A write addr=0x0010, wdata=0xDEADBEEF, wmask=0xF -> ram_cs=1, we=1, wem=0xF the same cycle; a_rsp_valid=1 next cycle with rdata=0.
  - Then A read 0x0010 -> a_rsp_rdata=0xDEADBEEF one cycle after grant.
- Contention: A and B both valid on reads for 4 cycles, rsp_ready=1 -> grants A,B,A,B; each rsp arrives 1 cycle after its grant.
- Backpressure: a_rsp_ready=0 after A's first read -> a_rsp_valid and a_rsp_rdata hold; a_cmd_ready stays 0 while B keeps being granted every cycle.
- Idle sleep: no requests for IDLE_CYC=16 cycles -> ram_ls=1 on cycle 17. A read then issued:
  - ram_ls=0 next cycle.
  - a_cmd_ready=0 for WAKE_CYC=2 cycles, then grant.
  - cs never high while ls=1.
- Deep sleep: in LS, assert pwr_deep_req -> ram_ds=1 and ram_ls=1. B request arrives -> WAKE, ds/ls drop, grant after 2 cycles; ram_sd stays 0 throughout.
- Async reset mid-operation: drop rst_n between clock edges while a_rsp_valid=1 and state is WAKE -> all outputs 0 immediately; after release the state is ACTIVE and the first request is granted the same cycle.
